stage_if_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline: owns the PC, drives the instruction-bus request/acknowledge handshake, and presents `if_register_pc`/`if_instruction` to the IF/ID latch. It sits directly upstream of that latch. It handles sequential fetch, delayed-branch redirects from ID and exception flushes from the pipeline controller, and raises `stall_request` while an instruction is not yet available.

---
 rtl/stage_if_fetch_pkg.sv | 23 ++
 rtl/stage_if_fetch_if.sv | 16 +
 rtl/stage_if_fetch_next_pc.sv | 19 +
 rtl/stage_if_fetch.sv | 127 ++++++++++++
 tb/tb_stage_if_fetch.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC,
// nop word, reset/stall polarities and the fetch FSM state encoding.
package stage_if_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned STALL_W = 6;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_FETCH   = 2'd1,
    FETCH_HOLD    = 2'd2,
    FETCH_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/stage_if_fetch_if.sv
// Instruction-bus handshake between the fetch stage (master) and memory (slave).
//   bus_request/bus_address : master -> slave, address held until bus_ack
//   bus_ack/bus_data        : slave -> master, data valid in the ack cycle
interface stage_if_fetch_if;
  import stage_if_fetch_pkg::*;

  logic            bus_request;
  logic [XLEN-1:0] bus_address;
  logic            bus_ack;
  logic [XLEN-1:0] bus_data;

  modport master (output bus_request, output bus_address,
                  input  bus_ack,     input  bus_data);
  modport slave  (input  bus_request, input  bus_address,
                  output bus_ack,     output bus_data);
endinterface

// File: rtl/stage_if_fetch_next_pc.sv
// Next-PC selection: taken-branch target or sequential PC + 4 (32-bit wrap).
//   pc, branch_enable, branch_target -> next_pc_c
module fetch_next_pc
  import stage_if_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            branch_enable,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc_c
);

  always_comb begin
    next_pc_c = pc + PC_STEP;
    if (branch_enable) begin
      next_pc_c = branch_target;
    end
  end

endmodule

// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the instruction-bus handshake and
// presents PC/instruction to the IF/ID latch.
//   clock, reset             : single clock, synchronous active-high reset
//   stall[0]                 : holds the fetch stage; stall[5:1] unused here
//   flush, flush_pc          : exception/eret redirect, highest priority
//   branch_enable/target     : taken branch in ID, applied after the delay slot
//   bus                      : instruction-bus master handshake
//   if_register_pc           : PC of the presented instruction
//   if_instruction           : presented instruction, nop when none is valid
//   stall_request            : fetch cannot supply an instruction this cycle
module stage_if_fetch
  import stage_if_fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    flush_pc,
  input  logic               branch_enable,
  input  logic [XLEN-1:0]    branch_target,
  stage_if_fetch_if.master   bus,
  output logic [XLEN-1:0]    if_register_pc,
  output logic [XLEN-1:0]    if_instruction,
  output logic               stall_request
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_address_q, req_address_d;
  logic [XLEN-1:0] buffer_q, buffer_d;
  logic [XLEN-1:0] next_pc_c;
  logic            stage_held_c;
  logic            unused_stall_c;

  assign stage_held_c   = (stall[0] == STALL_ENABLE);
  assign unused_stall_c = ^stall[STALL_W-1:1];
  assign if_register_pc = pc_q;

  fetch_next_pc u_next_pc (
    .pc            (pc_q),
    .branch_enable (branch_enable),
    .branch_target (branch_target),
    .next_pc_c     (next_pc_c)
  );

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      req_address_q <= RESET_PC;
      buffer_q      <= NOP_WORD;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_address_q <= req_address_d;
      buffer_q      <= buffer_d;
    end
  end

  // Next state, PC update and handshake outputs
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_address_d   = req_address_q;
    buffer_d        = buffer_q;
    bus.bus_request = 1'b0;
    bus.bus_address = req_address_q;
    if_instruction  = NOP_WORD;
    stall_request   = 1'b0;

    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_FETCH;
      end
      FETCH_FETCH: begin
        bus.bus_request = 1'b1;
        bus.bus_address = pc_q;
        req_address_d   = pc_q;
        if (bus.bus_ack) begin
          if_instruction = bus.bus_data;
          if (stage_held_c) begin
            // Park the word so the bus is free while the pipeline is stalled.
            buffer_d = bus.bus_data;
            state_d  = FETCH_HOLD;
          end else begin
            pc_d = next_pc_c;
          end
        end else begin
          stall_request = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if_instruction = buffer_q;
        if (stall[0] == STALL_DISABLE) begin
          pc_d    = next_pc_c;
          state_d = FETCH_FETCH;
        end
      end
      FETCH_DISCARD: begin
        // Old request is still outstanding; finish it and drop its data.
        bus.bus_request = 1'b1;
        stall_request   = 1'b1;
        if (bus.bus_ack) begin
          state_d = FETCH_FETCH;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    // Redirect overrides everything; an unacked request must still complete.
    if (flush) begin
      pc_d           = flush_pc;
      buffer_d       = NOP_WORD;
      if_instruction = NOP_WORD;
      stall_request  = 1'b0;
      if (state_q == FETCH_FETCH && !bus.bus_ack) begin
        state_d = FETCH_DISCARD;
      end else if (state_q != FETCH_DISCARD) begin
        state_d = FETCH_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_stage_if_fetch.sv
// Bench for stage_if_fetch: directed scenarios with explicit expectations,
// then randomized stall/flush/branch traffic against a wait-state memory,
// checked by a program-order PC model through a scoreboard queue.
module tb_stage_if_fetch;
  import stage_if_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_enable;
  logic [31:0] branch_target;
  logic [31:0] if_register_pc;
  logic [31:0] if_instruction;
  logic        stall_request;

  stage_if_fetch_if bus_if ();

  stage_if_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .branch_enable  (branch_enable),
    .branch_target  (branch_target),
    .bus            (bus_if),
    .if_register_pc (if_register_pc),
    .if_instruction (if_instruction),
    .stall_request  (stall_request)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } issue_t;

  int          errors = 0;
  int          checks = 0;
  issue_t      exp_q[$];
  bit          sb_on = 1'b0;
  int          issued = 0;
  logic [31:0] model_pc;

  // Memory model state: mem_cfg < 0 selects a random 0..3 wait per fetch
  int          mem_cfg = 0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  // Word stored at an address; never zero so it cannot alias the nop
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_step();
    bus_if.bus_ack  = 1'b0;
    bus_if.bus_data = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
    if (reset) begin
      mem_busy = 1'b0;
      return;
    end
    if (mem_busy) begin
      chk("bus_req_held", 32'(bus_if.bus_request), 32'd1);
      chk("bus_addr_stable", bus_if.bus_address, mem_addr);
    end
    if (bus_if.bus_request) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = bus_if.bus_address;
        mem_cnt  = (mem_cfg < 0) ? int'($urandom_range(0, 3)) : mem_cfg;
      end
      if (mem_cnt == 0) begin
        bus_if.bus_ack  = 1'b1;
        bus_if.bus_data = mem_word(mem_addr);
        mem_busy        = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  // One clock cycle: drive inputs after the edge, respond from memory, settle
  task automatic cyc(input logic rst, input logic st0, input logic fl,
                     input logic [31:0] fpc, input logic be, input logic [31:0] bt);
    @(posedge clock);
    #1;
    reset         = rst;
    stall         = {5'($urandom_range(0, 31)), st0};
    flush         = fl;
    flush_pc      = fpc;
    branch_enable = be;
    branch_target = bt;
    mem_step();
    #1;
  endtask

  task automatic chk_bus(input string name, input logic req, input logic [31:0] addr);
    chk({name, "_req"}, 32'(bus_if.bus_request), 32'(req));
    chk({name, "_addr"}, bus_if.bus_address, addr);
  endtask

  task automatic chk_out(input string name, input logic [31:0] instr, input logic streq);
    chk({name, "_instr"}, if_instruction, instr);
    chk({name, "_streq"}, 32'(stall_request), 32'(streq));
  endtask

  // Scoreboard monitor: pops an expectation whenever the IF/ID latch accepts
  always @(negedge clock) begin
    if (sb_on && !reset && !flush && !stall[0] && !stall_request && if_instruction != 32'h0) begin
      issue_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pc %h instr %h required none", if_register_pc, if_instruction);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", if_register_pc, e.pc);
        chk("sb_instr", if_instruction, e.instr);
        issued++;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic        st;
    logic        fl;
    logic        be;
    logic [31:0] fpc;
    logic [31:0] bt;
    issue_t      e;

    reset = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0;
    branch_enable = 1'b0; branch_target = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_data = '0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk_bus("rst", 1'b0, RESET_PC);
    chk("rst_pc", if_register_pc, RESET_PC);
    chk_out("rst", 32'h0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_bus("idle", 1'b0, RESET_PC);

    // Zero-wait sequential fetch with a branch issued while fetching 8
    for (int i = 0; i < 3; i++) begin
      a = 32'(4 * i);
      cyc(0, 0, 0, 0, (a == 32'h8), 32'h100);
      chk_bus("seq", 1'b1, a);
      chk("seq_pc", if_register_pc, a);
      chk_out("seq", mem_word(a), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      a = 32'h100 + 32'(4 * i);
      cyc(0, 0, 0, 0, 0, 0);
      chk_bus("br", 1'b1, a);
      chk_out("br", mem_word(a), 1'b0);
    end

    // Two-wait memory: address held 3 cycles, stalled for 2
    mem_cfg = 2;
    for (int i = 0; i < 6; i++) begin
      a = 32'h108 + 32'(4 * (i / 3));
      cyc(0, 0, 0, 0, 0, 0);
      chk_bus("wait2", 1'b1, a);
      chk_out("wait2", (i % 3 == 2) ? mem_word(a) : 32'h0, (i % 3 != 2));
    end
    mem_cfg = 0;

    // Stage stall on the ack cycle: HOLD presents the buffered word
    cyc(0, 1, 0, 0, 0, 0);
    chk_bus("hold_ack", 1'b1, 32'h110);
    for (int i = 0; i < 3; i++) begin
      cyc(0, (i < 2), 0, 0, 0, 0);
      chk("hold_req", 32'(bus_if.bus_request), 32'd0);
      chk("hold_pc", if_register_pc, 32'h110);
      chk_out("hold", mem_word(32'h110), 1'b0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk_bus("hold_rel", 1'b1, 32'h114);
    chk_out("hold_rel", mem_word(32'h114), 1'b0);

    // Flush coinciding with ack: data dropped, redirect next cycle
    cyc(0, 0, 1, 32'h20, 0, 0);
    chk_bus("flack", 1'b1, 32'h118);
    chk_out("flack", 32'h0, 1'b0);
    mem_cfg = 3;
    // Flush during an unacked fetch of 0x20: old address held to completion
    cyc(0, 0, 1, 32'h180, 0, 0);
    chk_bus("flpend", 1'b1, 32'h20);
    chk_out("flpend", 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk_bus("discard", 1'b1, 32'h20);
      chk_out("discard", 32'h0, 1'b1);
    end
    mem_cfg = 0;
    cyc(0, 0, 0, 0, 0, 0);
    chk_bus("flnew", 1'b1, 32'h180);
    chk_out("flnew", mem_word(32'h180), 1'b0);

    // PC wraps from the top of the address space to zero
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_bus("wrap_top", 1'b1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0);
    chk_bus("wrap_zero", 1'b1, 32'h0);
    chk_out("wrap_zero", mem_word(32'h0), 1'b0);

    // Reset mid-request: request abandoned the next cycle
    mem_cfg = 3;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_bus("rstmid", 1'b0, RESET_PC);
    chk("rstmid_pc", if_register_pc, RESET_PC);
    chk_out("rstmid", 32'h0, 1'b0);
    mem_cfg = 0;
    cyc(0, 0, 0, 0, 0, 0);
    chk_bus("rstmid_fetch", 1'b1, RESET_PC);

    // Randomized traffic checked in program order through the scoreboard
    mem_cfg = -1;
    cyc(1, 0, 0, 0, 0, 0);
    model_pc = RESET_PC;
    sb_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 3);
      be  = ($urandom_range(0, 99) < 15);
      fpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : (32'($urandom) & 32'hFFFF_FFFC);
      bt  = 32'($urandom) & 32'hFFFF_FFFC;
      cyc(0, st, fl, fpc, be, bt);
      if (!flush && !stall[0] && !stall_request && if_instruction != 32'h0) begin
        e.pc    = model_pc;
        e.instr = mem_word(model_pc);
        exp_q.push_back(e);
        model_pc = branch_enable ? branch_target : model_pc + 32'd4;
      end
      if (flush) begin
        model_pc = flush_pc;
      end
    end
    @(negedge clock);
    #1;
    sb_on = 1'b0;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    checks++;
    if (issued < 500) begin
      errors++;
      $display("FAIL sb_throughput: got %0d issued required at least 500", issued);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
